// File: rtl/mc_point_gen.sv
// Monte-Carlo point generator: LFSR-driven points on a rate-selectable tick, windowed to a square and handed off with valid/ready.
// Optional squarer/circle test and hit counter are built when MC_POINT_GEN_HIT_COUNT_EN is defined.
module mc_point_gen #(
  parameter int                     COORD_W    = 9,
  parameter int                     RATE_SEL_W = 2,
  parameter int                     BASE_SHIFT = 10,
  parameter int                     RATE_STEP  = 2,
  parameter int                     CNT_W      = 24,
  parameter int                     RADIUS     = 480,
  parameter logic [2*COORD_W-1:0]   TAPS       = 18'h20400
) (
  input  logic                    clk10,
  input  logic                    reset,
  input  logic [RATE_SEL_W-1:0]   rate_sel,
  input  logic                    start,
  input  logic                    stop,
  input  logic [2*COORD_W-1:0]    seed,
  input  logic [CNT_W-1:0]        sample_limit,
  output logic                    pt_valid,
  input  logic                    pt_ready,
  output logic [COORD_W-1:0]      pt_x,
  output logic [COORD_W-1:0]      pt_y,
  output logic                    pt_inside,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic                    busy,
  output logic                    done
);

  localparam int LFSR_W    = 2 * COORD_W;
  localparam int NUM_RATES = 2 ** RATE_SEL_W;
  localparam int DIV_W     = BASE_SHIFT + (NUM_RATES - 1) * RATE_STEP;
  localparam int SQ_W      = 2 * COORD_W + 2;

  localparam logic [COORD_W-1:0] RAD_C  = COORD_W'(RADIUS);
  localparam logic [SQ_W-1:0]    RAD_SQ = SQ_W'(RADIUS * RADIUS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [DIV_W-1:0]   r_div;
  logic [LFSR_W-1:0]  r_lfsr;
  logic               r_eval;
  logic [CNT_W-1:0]   r_limit;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_hit;
  logic               r_pt_valid;
  logic [COORD_W-1:0] r_pt_x;
  logic [COORD_W-1:0] r_pt_y;
  logic               r_pt_inside;

  logic [DIV_W-1:0]   w_mask;
  logic               w_tick;
  logic [LFSR_W-1:0]  w_lfsr_step;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_in_win;
  logic               w_inside;
  logic               w_xfer;
  logic [CNT_W-1:0]   w_total_nxt;
  logic [CNT_W-1:0]   w_hit_nxt;

  // Slower rates compare more DIV bits; the mask follows rate_sel combinationally, so a change never resets DIV.
  assign w_mask = {DIV_W{1'b1}} >> (int'(rate_sel) * RATE_STEP);
  assign w_tick = ((r_div & w_mask) == '0);

  assign w_lfsr_step = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
  assign w_x         = r_lfsr[LFSR_W-1:COORD_W];
  assign w_y         = r_lfsr[COORD_W-1:0];
  assign w_in_win    = (w_x <= RAD_C) && (w_y <= RAD_C);

`ifdef MC_POINT_GEN_HIT_COUNT_EN
  logic [SQ_W-1:0] w_sum_sq;
  assign w_sum_sq = SQ_W'(w_x) * SQ_W'(w_x) + SQ_W'(w_y) * SQ_W'(w_y);
  assign w_inside = (w_sum_sq <= RAD_SQ);
`else
  assign w_inside = 1'b0;
`endif

  assign w_xfer      = r_pt_valid && pt_ready;
  assign w_total_nxt = (&r_total) ? r_total : r_total + 1'b1;
  assign w_hit_nxt   = (r_pt_inside && !(&r_hit)) ? r_hit + 1'b1 : r_hit;

  // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values of its peers.
  always_ff @(posedge clk10) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_lfsr      <= LFSR_W'(1);
      r_eval      <= 1'b0;
      r_limit     <= '0;
      r_total     <= '0;
      r_hit       <= '0;
      r_pt_valid  <= 1'b0;
      r_pt_x      <= '0;
      r_pt_y      <= '0;
      r_pt_inside <= 1'b0;
    end else begin
      r_div <= r_div + 1'b1;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (start) begin
            r_state <= S_RUN;
            r_total <= '0;
            r_hit   <= '0;
            r_limit <= sample_limit;
            r_lfsr  <= (seed == '0) ? LFSR_W'(1) : seed;
            r_eval  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_eval  <= 1'b0;
          end else if (r_eval) begin
            // The candidate is judged the cycle after the LFSR stepped.
            r_eval <= 1'b0;
            if (w_in_win) begin
              r_pt_x      <= w_x;
              r_pt_y      <= w_y;
              r_pt_inside <= w_inside;
              r_pt_valid  <= 1'b1;
              r_state     <= S_HOLD;
            end
          end else if (w_tick) begin
            r_lfsr <= w_lfsr_step;
            r_eval <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_xfer) begin
            r_total    <= w_total_nxt;
            r_hit      <= w_hit_nxt;
            r_pt_valid <= 1'b0;
          end
          if (stop) begin
            r_state    <= S_IDLE;
            r_pt_valid <= 1'b0;
          end else if (w_xfer) begin
            r_state <= ((r_limit != '0) && (w_total_nxt == r_limit)) ? S_DONE : S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pt_valid  = r_pt_valid;
  assign pt_x      = r_pt_x;
  assign pt_y      = r_pt_y;
  assign pt_inside = r_pt_inside;
  assign total_cnt = r_total;
  assign hit_cnt   = r_hit;
  assign busy      = (r_state == S_RUN) || (r_state == S_HOLD);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_mc_point_gen.sv
// Self-checking bench for mc_point_gen: random seeds checked against a tick-by-tick point model
// derived from the LFSR recurrence, the square window and the tick period of each rate.
module tb_mc_point_gen;

  localparam int COORD_W = 9;
  localparam int LW      = 2 * COORD_W;
  localparam int CNT_W   = 24;
  localparam int RADIUS  = 480;
  localparam logic [LW-1:0] TAPS = 18'h20400;

  logic              clk10;
  logic              reset;
  logic [1:0]        rate_sel;
  logic              start;
  logic              stop;
  logic [LW-1:0]     seed;
  logic [CNT_W-1:0]  sample_limit;
  logic              pt_valid;
  logic              pt_ready;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic              pt_inside;
  logic [CNT_W-1:0]  total_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic              busy;
  logic              done;

  mc_point_gen dut (
    .clk10(clk10), .reset(reset), .rate_sel(rate_sel), .start(start), .stop(stop),
    .seed(seed), .sample_limit(sample_limit), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_inside(pt_inside), .total_cnt(total_cnt),
    .hit_cnt(hit_cnt), .busy(busy), .done(done)
  );

  initial clk10 = 1'b0;
  always #5 clk10 = ~clk10;

  // Cycle index since reset release; equals the free-running divider value while it has not wrapped.
  int cyc;
  always @(posedge clk10) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model state
  logic [LW-1:0] m_lfsr;
  int            m_total;
  int            m_hit;
  int            m_in;

  function automatic logic [LW-1:0] lfsr_next(input logic [LW-1:0] q);
    return {q[LW-2:0], ^(q & TAPS)};
  endfunction

  function automatic int exp_inside(input int x, input int y);
`ifdef MC_POINT_GEN_HIT_COUNT_EN
    return (x * x + y * y <= RADIUS * RADIUS) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // First accepted point from eligible cycle e onward: ticks fall on multiples of the period,
  // each steps the LFSR, and an accepted point is visible two cycles after its tick.
  task automatic predict(input int e, input int period, output int v, output int ex, output int ey);
    int t;
    t = e;
    v = -1; ex = 0; ey = 0;
    for (int k = 0; k < 64; k++) begin
      t = ((t + period - 1) / period) * period;
      m_lfsr = lfsr_next(m_lfsr);
      ex = int'(m_lfsr[LW-1:COORD_W]);
      ey = int'(m_lfsr[COORD_W-1:0]);
      if (ex <= RADIUS && ey <= RADIUS) begin
        v = t + 2;
        return;
      end
      t = t + 1;
    end
  endtask

  task automatic wait_valid(input int v, output int got);
    int budget;
    budget = (v > cyc) ? (v - cyc + 16) : 16;
    got = -1;
    for (int k = 0; k < budget; k++) begin
      if (pt_valid) begin
        got = cyc;
        return;
      end
      @(negedge clk10);
    end
    check("valid_timeout", pt_valid, 1);
  endtask

  task automatic check_point(input string tag, input int v, input int ex, input int ey);
    int got;
    wait_valid(v, got);
    check({tag, "_cycle"}, got, v);
    check({tag, "_x"}, pt_x, ex);
    check({tag, "_y"}, pt_y, ey);
    m_in = exp_inside(ex, ey);
    check({tag, "_inside"}, pt_inside, m_in);
  endtask

  task automatic get_point(input string tag, input int period, input int e);
    int v, ex, ey;
    predict(e, period, v, ex, ey);
    check_point(tag, v, ex, ey);
  endtask

  task automatic accept(input string tag);
    pt_ready = 1'b1;
    @(negedge clk10);
    pt_ready = 1'b0;
    m_total++;
    m_hit += m_in;
    check({tag, "_vfall"}, pt_valid, 0);
    check({tag, "_total"}, total_cnt, m_total);
    check({tag, "_hit"}, hit_cnt, m_hit);
  endtask

  task automatic pulse_start(input logic [LW-1:0] s, input int limit);
    seed = s;
    sample_limit = CNT_W'(limit);
    start = 1'b1;
    @(negedge clk10);
    start = 1'b0;
    m_lfsr  = (s == '0) ? LW'(1) : s;
    m_total = 0;
    m_hit   = 0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk10);
    stop = 1'b0;
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, ex, ey, got, t1, seen, stable;
    logic [COORD_W-1:0] hx, hy;
    logic [LW-1:0] s, nq;

    reset = 1'b1; rate_sel = 2'd3; start = 1'b0; stop = 1'b0;
    seed = '0; sample_limit = '0; pt_ready = 1'b0;
    m_lfsr = LW'(1); m_total = 0; m_hit = 0; m_in = 0;
    repeat (3) @(negedge clk10);
    check("rst_valid", pt_valid, 0);
    check("rst_x", pt_x, 0);
    check("rst_y", pt_y, 0);
    check("rst_inside", pt_inside, 0);
    check("rst_total", total_cnt, 0);
    check("rst_hit", hit_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Slowest rate: no tick may land on a 1024 boundary; switching to rate 3 takes effect at once.
    rate_sel = 2'd0;
    pulse_start(LW'($urandom), 0);
    check("run_busy", busy, 1);
    seen = 0;
    while (cyc < 3500) begin
      seen |= int'(pt_valid);
      @(negedge clk10);
    end
    check("rate0_quiet", seen, 0);
    rate_sel = 2'd3;
    get_point("rate3_a", 1024, cyc);
    accept("rate3_a");
    get_point("rate3_b", 1024, cyc);
    accept("rate3_b");
    pulse_stop();
    check("stop_busy", busy, 0);
    check("stop_total_kept", total_cnt, 2);

    // Zero seed loads 1; first tick gives (0,2).
    pulse_start('0, 0);
    predict(cyc, 1024, v, ex, ey);
    check_point("seed0", v, ex, ey);
    check("seed0_y2", pt_y, 2);
    check("seed0_x0", pt_x, 0);

    // Hold the point across three ticks; a start while busy must be ignored.
    hx = pt_x; hy = pt_y; stable = 1;
    for (int k = 0; k < 3 * 1024 + 8; k++) begin
      if (k == 100) start = 1'b1;
      if (k == 101) start = 1'b0;
      if (k == 100) seed = LW'($urandom);
      stable &= int'(pt_valid && pt_x == hx && pt_y == hy && busy && total_cnt == 0);
      @(negedge clk10);
    end
    check("hold_stable", stable, 1);
    accept("hold_xfer");
    for (int k = 0; k < 4; k++) begin
      get_point("flow", 1024, cyc);
      accept("flow");
    end
    pulse_stop();

    // Medium rate.
    rate_sel = 2'd2;
    pulse_start(LW'($urandom), 0);
    for (int k = 0; k < 2; k++) begin
      get_point("rate2", 4096, cyc);
      accept("rate2");
    end
    pulse_stop();

    // Seed whose first candidate has x=500: discarded without a count change.
    rate_sel = 2'd3;
    s = '0;
    for (int k = 0; k < 200000; k++) begin
      s = LW'($urandom);
      nq = lfsr_next(s);
      if (nq[LW-1:COORD_W] == 9'd500) break;
    end
    pulse_start(s, 0);
    t1 = ((cyc + 1023) / 1024) * 1024;
    predict(cyc, 1024, v, ex, ey);
    seen = 0;
    while (cyc < t1 + 4) begin
      seen |= int'(pt_valid);
      @(negedge clk10);
    end
    check("x500_novalid", seen, 0);
    check("x500_total", total_cnt, 0);
    check_point("x500_next", v, ex, ey);
    accept("x500_next");
    pulse_stop();

    // Limited run of four samples.
    pulse_start(LW'($urandom), 4);
    for (int k = 0; k < 4; k++) begin
      get_point("lim4", 1024, cyc);
      accept("lim4");
    end
    check("lim4_done", done, 1);
    check("lim4_busy", busy, 0);
    repeat (1100) @(negedge clk10);
    check("lim4_held_total", total_cnt, 4);
    check("lim4_held_hit", hit_cnt, m_hit);
    check("lim4_held_valid", pt_valid, 0);
    check("lim4_held_done", done, 1);
    pulse_start(LW'($urandom), 2);
    check("restart_total", total_cnt, 0);
    check("restart_hit", hit_cnt, 0);
    check("restart_busy", busy, 1);
    for (int k = 0; k < 2; k++) begin
      get_point("lim2", 1024, cyc);
      accept("lim2");
    end
    check("lim2_done", done, 1);

    // stop from DONE, then start+stop together: stop wins.
    pulse_stop();
    check("done_stop_done", done, 0);
    check("done_stop_busy", busy, 0);
    start = 1'b1; stop = 1'b1; seed = LW'($urandom);
    @(negedge clk10);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_total", total_cnt, 2);

    // Transfer coincident with stop is counted.
    pulse_start(LW'($urandom), 0);
    get_point("xstop", 1024, cyc);
    pt_ready = 1'b1; stop = 1'b1;
    @(negedge clk10);
    pt_ready = 1'b0; stop = 1'b0;
    m_total++;
    m_hit += m_in;
    check("xstop_valid", pt_valid, 0);
    check("xstop_busy", busy, 0);
    check("xstop_total", total_cnt, m_total);
    check("xstop_hit", hit_cnt, m_hit);

    // Reset in HOLD drops the point without a handshake.
    pulse_start(LW'($urandom), 0);
    get_point("rsthold", 1024, cyc);
    reset = 1'b1;
    @(negedge clk10);
    reset = 1'b0;
    check("rsthold_valid", pt_valid, 0);
    check("rsthold_busy", busy, 0);
    check("rsthold_x", pt_x, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
